wallclock_mode_ctrl: RTL and testbench
======================================

Name: wallclock_mode_ctrl

Overview:
- Mode/time-set sequencer for the wall clock.
- Accepts debounced single-cycle button pulses (Mode, Inc) and drives the timekeeping and alarm datapaths.
  - Issues one-cycle increment strobes to the time and alarm-time registers.
  - Freezes seconds while minutes are being set.
  - Generates a per-digit blank mask so the seven-segment driver blinks the field under edit.
- Sits between the Debounce instances and the time/alarm registers and display driver.

Parameters:
- BLINK_DIV, 50000000, clock cycles per blink half-period (visible or blanked); minimum 2.
- TIMEOUT_S, 10, seconds of button inactivity in any set state before automatic return to RUN; minimum 1.
- CNT_W, 27, width of the internal blink counter; must hold BLINK_DIV-1.

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- nReset  in  1  synchronous, active-low reset.
- btnMode  in  1  debounced one-cycle pulse; advance mode.
- btnInc  in  1  debounced one-cycle pulse; increment the selected field.
- tickSec  in  1  one-cycle pulse per second from the timekeeping counter.
- mode  out  3  current state encoding.
- incHrs  out  1  one-cycle strobe: time hours +1.
- incMins  out  1  one-cycle strobe: time minutes +1.
- incAlmHrs  out  1  one-cycle strobe: alarm hours +1.
- incAlmMins  out  1  one-cycle strobe: alarm minutes +1.
- holdSeconds  out  1  level; seconds counter frozen while high.
- secClear  out  1  one-cycle strobe: clear seconds to 0.
- almEnable  out  1  level; alarm armed.
- showAlarm  out  1  level; display mux selects alarm time.
- digitBlank  out  4  per-digit blank mask {H2,H1,M2,M1}; 1 = blanked.

Behaviour:
- Reset (nReset=0 at a clock edge) forces:
  - mode=RUN; all strobes=0; holdSeconds=0; almEnable=0; showAlarm=0; digitBlank=0000.
  - Blink counter=0, blink phase=visible, timeout counter=0.
- Reset mid-edit discards the edit state; strobes already issued are not undone.
- States and encoding: RUN=0, SET_HRS=1, SET_MIN=2, ALM_HRS=3, ALM_MIN=4. Codes 5-7 are illegal and recover to RUN on the next edge.
- Mode transitions on btnMode: RUN -> SET_HRS -> SET_MIN -> ALM_HRS -> ALM_MIN -> RUN.
- btnInc by state:
  - RUN: toggles almEnable.
  - SET_HRS: incHrs.
  - SET_MIN: incMins.
  - ALM_HRS: incAlmHrs.
  - ALM_MIN: incAlmMins.
- Latency: strobes are registered; btnInc at edge N gives strobe high for exactly cycle N+1. Never two strobes in the same cycle.
- Simultaneous btnMode and btnInc: btnMode wins, btnInc is dropped (no strobe, no almEnable toggle).
- holdSeconds = 1 exactly while mode==SET_MIN.
- secClear pulses for one cycle on the SET_MIN -> ALM_HRS transition and on a timeout exit from SET_MIN.
- showAlarm = 1 while mode is ALM_HRS or ALM_MIN.
- Blink:
  - Counter counts 0..BLINK_DIV-1 and wraps; phase toggles on each wrap.
  - Counter and phase reset to 0/visible on every state entry and on every btnInc in a set state.
  - digitBlank = 1100 in SET_HRS/ALM_HRS when phase=blanked, 0011 in SET_MIN/ALM_MIN when phase=blanked, otherwise 0000.
  - Always 0000 in RUN.
- Timeout:
  - In a set state, the counter increments on tickSec and clears on any btnMode, btnInc, or state change.
  - When it reaches TIMEOUT_S, the next edge moves mode to RUN and clears the counter.
  - tickSec coinciding with a button: the button clear wins.
  - Counter is held at 0 in RUN.
- Wrap-around of hour and minute values is the datapath's responsibility; this block only strobes.

Optional Feature:
- MODE_TIMEOUT_EN defined: inactivity timeout active as described; the tickSec input is used.
- MODE_TIMEOUT_EN undefined: no timeout counter. Set states persist until btnMode, tickSec is ignored, and the secClear timeout exit is absent.

Test Plan:
- Bench uses BLINK_DIV=4, TIMEOUT_S=3.
- Reset: nReset=0 for 2 cycles with buttons active -> mode=0, digitBlank=0000, almEnable=0, no strobes.
- 5 btnMode pulses from RUN -> mode sequence 1,2,3,4,0. showAlarm high only at modes 3-4. holdSeconds high only at mode 2. One secClear on the 2->3 transition.
- In SET_HRS, btnInc at cycle 10 -> incHrs=1 at cycle 11 only. digitBlank=0000 for 4 cycles, then 1100 for 4 cycles, alternating.
- btnMode and btnInc together in SET_MIN -> mode=3, no incMins, no secClear loss (exactly one pulse).
- With MODE_TIMEOUT_EN, in ALM_MIN with 3 tickSec and no buttons -> mode=0 one cycle after the third tick. A btnInc between ticks restarts the count. Without the macro -> mode stays 4.
- In RUN, btnInc twice -> almEnable 0->1->0. No inc strobes issued.

Source files
------------

// File: rtl/wallclock_mode_ctrl_if.sv
// Button/tick inputs and control outputs of the wall-clock mode sequencer.
// master drives the buttons and tick; slave is the sequencer.
interface wallclock_mode_ctrl_if;
  logic       btnMode;
  logic       btnInc;
  logic       tickSec;
  logic [2:0] mode;
  logic       incHrs;
  logic       incMins;
  logic       incAlmHrs;
  logic       incAlmMins;
  logic       holdSeconds;
  logic       secClear;
  logic       almEnable;
  logic       showAlarm;
  logic [3:0] digitBlank;

  modport master (
    output btnMode, btnInc, tickSec,
    input  mode, incHrs, incMins, incAlmHrs, incAlmMins,
    input  holdSeconds, secClear, almEnable, showAlarm, digitBlank
  );

  modport slave (
    input  btnMode, btnInc, tickSec,
    output mode, incHrs, incMins, incAlmHrs, incAlmMins,
    output holdSeconds, secClear, almEnable, showAlarm, digitBlank
  );
endinterface

// File: rtl/wallclock_mode_ctrl.sv
// Wall-clock mode/time-set sequencer: edit FSM, increment strobes, seconds hold and blink mask.
// Define MODE_TIMEOUT_EN to enable the tickSec-driven inactivity return to RUN.
module wallclock_mode_ctrl #(
  parameter int unsigned BLINK_DIV = 50000000,
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned CNT_W     = 27
) (
  input logic                  CLK100MHZ,
  input logic                  nReset,
  wallclock_mode_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StSetHrs = 3'd1,
    StSetMin = 3'd2,
    StAlmHrs = 3'd3,
    StAlmMin = 3'd4
  } mode_e;

  localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_DIV - 1);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             alm_en_q, alm_en_d;
  logic [3:0]       inc_q, inc_d;  // {hrs, mins, alm hrs, alm mins}
  logic             sec_clr_q, sec_clr_d;
  logic             hold_q, show_alm_q;
  logic [3:0]       blank_q, blank_d;
  logic             set_state, timeout_exit;

`ifdef MODE_TIMEOUT_EN
  localparam int unsigned   TmrW    = $clog2(TIMEOUT_S + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_S);
  logic [TmrW-1:0] tmr_q, tmr_d;
`else
  logic unused_tick;
  assign unused_tick = bus.tickSec;
`endif

  always_comb begin
    set_state    = mode_q inside {StSetHrs, StSetMin, StAlmHrs, StAlmMin};
    mode_d       = mode_q;
    inc_d        = 4'b0000;
    sec_clr_d    = 1'b0;
    alm_en_d     = alm_en_q;
    timeout_exit = 1'b0;
`ifdef MODE_TIMEOUT_EN
    timeout_exit = set_state && !bus.btnMode && !bus.btnInc && (tmr_q >= TmrLast);
`endif

    // btnMode takes priority; a simultaneous btnInc is dropped.
    case (mode_q)
      StRun: begin
        if (bus.btnMode)     mode_d   = StSetHrs;
        else if (bus.btnInc) alm_en_d = ~alm_en_q;
      end
      StSetHrs: begin
        if (bus.btnMode)     mode_d = StSetMin;
        else if (bus.btnInc) inc_d  = 4'b1000;
      end
      StSetMin: begin
        if (bus.btnMode) begin
          mode_d    = StAlmHrs;
          sec_clr_d = 1'b1;
        end else if (bus.btnInc) begin
          inc_d = 4'b0100;
        end
      end
      StAlmHrs: begin
        if (bus.btnMode)     mode_d = StAlmMin;
        else if (bus.btnInc) inc_d  = 4'b0010;
      end
      StAlmMin: begin
        if (bus.btnMode)     mode_d = StRun;
        else if (bus.btnInc) inc_d  = 4'b0001;
      end
      default: mode_d = StRun;
    endcase

    if (timeout_exit) begin
      mode_d    = StRun;
      sec_clr_d = (mode_q == StSetMin);
    end

    blink_cnt_d   = blink_cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if ((mode_d != mode_q) || (set_state && bus.btnInc) || (mode_d == StRun)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    blank_d = 4'b0000;
    if (blink_phase_d) begin
      case (mode_d)
        StSetHrs, StAlmHrs: blank_d = 4'b1100;
        StSetMin, StAlmMin: blank_d = 4'b0011;
        default:            blank_d = 4'b0000;
      endcase
    end

`ifdef MODE_TIMEOUT_EN
    if (!set_state || bus.btnMode || bus.btnInc || (mode_d != mode_q)) tmr_d = '0;
    else if (bus.tickSec)                                               tmr_d = tmr_q + TmrW'(1);
    else                                                                tmr_d = tmr_q;
`endif
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!nReset) begin
      mode_q        <= StRun;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      alm_en_q      <= 1'b0;
      inc_q         <= 4'b0000;
      sec_clr_q     <= 1'b0;
      hold_q        <= 1'b0;
      show_alm_q    <= 1'b0;
      blank_q       <= 4'b0000;
`ifdef MODE_TIMEOUT_EN
      tmr_q         <= '0;
`endif
    end else begin
      mode_q        <= mode_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      alm_en_q      <= alm_en_d;
      inc_q         <= inc_d;
      sec_clr_q     <= sec_clr_d;
      hold_q        <= (mode_d == StSetMin);
      show_alm_q    <= (mode_d == StAlmHrs) || (mode_d == StAlmMin);
      blank_q       <= blank_d;
`ifdef MODE_TIMEOUT_EN
      tmr_q         <= tmr_d;
`endif
    end
  end

  assign bus.mode        = mode_q;
  assign bus.incHrs      = inc_q[3];
  assign bus.incMins     = inc_q[2];
  assign bus.incAlmHrs   = inc_q[1];
  assign bus.incAlmMins  = inc_q[0];
  assign bus.holdSeconds = hold_q;
  assign bus.secClear    = sec_clr_q;
  assign bus.almEnable   = alm_en_q;
  assign bus.showAlarm   = show_alm_q;
  assign bus.digitBlank  = blank_q;
endmodule

// File: tb/tb_wallclock_mode_ctrl.sv
// Self-checking bench for wallclock_mode_ctrl (BLINK_DIV=4, TIMEOUT_S=3).
// Builds with or without MODE_TIMEOUT_EN; timeout expectations follow the macro.
module tb_wallclock_mode_ctrl;
  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] inc;    // {incHrs, incMins, incAlmHrs, incAlmMins}
    logic       hold;
    logic       sclr;
    logic       alm;
    logic       show;
    logic [3:0] blank;
  } out_t;

  typedef struct {
    logic m;
    logic i;
    logic t;
    out_t e;
  } vec_t;

  localparam logic [3:0] NO  = 4'b0000;
  localparam logic [3:0] IH  = 4'b1000;
  localparam logic [3:0] IM  = 4'b0100;
  localparam logic [3:0] IAH = 4'b0010;
  localparam logic [3:0] IAM = 4'b0001;
  localparam logic [3:0] B0  = 4'b0000;
  localparam logic [3:0] BH  = 4'b1100;
  localparam logic [3:0] BM  = 4'b0011;

  logic CLK100MHZ = 1'b0;
  logic nReset    = 1'b0;
  int   tests     = 0;
  int   failed    = 0;
  out_t exp_q[$];
  vec_t tbl[25];

  always #5 CLK100MHZ = ~CLK100MHZ;

  wallclock_mode_ctrl_if bus ();

  wallclock_mode_ctrl #(
    .BLINK_DIV(4),
    .TIMEOUT_S(3),
    .CNT_W    (27)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .nReset   (nReset),
    .bus      (bus)
  );

  // hold and showAlarm follow directly from the mode code.
  function automatic out_t ex(input int unsigned md, input logic [3:0] inc, input logic sclr,
                              input logic alm, input logic [3:0] blank);
    out_t o;
    o.mode  = 3'(md);
    o.inc   = inc;
    o.hold  = (md == 2);
    o.sclr  = sclr;
    o.alm   = alm;
    o.show  = (md == 3) || (md == 4);
    o.blank = blank;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("mode=%0d inc=%b hold=%b sclr=%b alm=%b show=%b blank=%b",
                     o.mode, o.inc, o.hold, o.sclr, o.alm, o.show, o.blank);
  endfunction

  // Called at a falling edge: drive, clock once, sample at the next falling edge.
  task automatic step(input logic m, input logic i, input logic t, input out_t e,
                      input string nm);
    out_t got;
    out_t want;
    exp_q.push_back(e);
    bus.btnMode = m;
    bus.btnInc  = i;
    bus.tickSec = t;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    got.mode  = bus.mode;
    got.inc   = {bus.incHrs, bus.incMins, bus.incAlmHrs, bus.incAlmMins};
    got.hold  = bus.holdSeconds;
    got.sclr  = bus.secClear;
    got.alm   = bus.almEnable;
    got.show  = bus.showAlarm;
    got.blank = bus.digitBlank;
    want = exp_q.pop_front();
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %s, required %s", nm, fmt(got), fmt(want));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // RUN-based walk; dwell in each set state stays under 4 cycles so blink stays visible.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, ex(0, NO,  0, 0, B0)};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, ex(1, NO,  0, 0, B0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, ex(2, NO,  0, 0, B0)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, ex(3, NO,  1, 0, B0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, ex(4, NO,  0, 0, B0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, ex(0, NO,  0, 0, B0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, ex(0, NO,  0, 1, B0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, ex(0, NO,  0, 1, B0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, ex(0, NO,  0, 0, B0)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, ex(1, NO,  0, 0, B0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, ex(1, IH,  0, 0, B0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, ex(1, NO,  0, 0, B0)};
    tbl[12] = '{1'b1, 1'b0, 1'b0, ex(2, NO,  0, 0, B0)};
    tbl[13] = '{1'b0, 1'b1, 1'b0, ex(2, IM,  0, 0, B0)};
    tbl[14] = '{1'b1, 1'b1, 1'b0, ex(3, NO,  1, 0, B0)};
    tbl[15] = '{1'b0, 1'b1, 1'b0, ex(3, IAH, 0, 0, B0)};
    tbl[16] = '{1'b1, 1'b0, 1'b0, ex(4, NO,  0, 0, B0)};
    tbl[17] = '{1'b0, 1'b1, 1'b0, ex(4, IAM, 0, 0, B0)};
    tbl[18] = '{1'b1, 1'b0, 1'b0, ex(0, NO,  0, 0, B0)};
    tbl[19] = '{1'b1, 1'b1, 1'b0, ex(1, NO,  0, 0, B0)};
    tbl[20] = '{1'b0, 1'b1, 1'b0, ex(1, IH,  0, 0, B0)};
    tbl[21] = '{1'b1, 1'b0, 1'b0, ex(2, NO,  0, 0, B0)};
    tbl[22] = '{1'b1, 1'b0, 1'b0, ex(3, NO,  1, 0, B0)};
    tbl[23] = '{1'b1, 1'b0, 1'b0, ex(4, NO,  0, 0, B0)};
    tbl[24] = '{1'b1, 1'b0, 1'b0, ex(0, NO,  0, 0, B0)};

    bus.btnMode = 1'b0;
    bus.btnInc  = 1'b0;
    bus.tickSec = 1'b0;
    @(negedge CLK100MHZ);

    // Reset with buttons held active.
    nReset = 1'b0;
    step(1'b1, 1'b1, 1'b1, ex(0, NO, 0, 0, B0), "reset_0");
    step(1'b1, 1'b1, 1'b1, ex(0, NO, 0, 0, B0), "reset_1");
    nReset = 1'b1;

    foreach (tbl[k]) step(tbl[k].m, tbl[k].i, tbl[k].t, tbl[k].e, $sformatf("vec_%0d", k));

    // Blink in SET_HRS: 4 cycles visible from the btnInc, then 4 blanked, alternating.
    step(1'b1, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "blink_enter");
    step(1'b0, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "blink_pre1");
    step(1'b0, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "blink_pre2");
    step(1'b0, 1'b1, 1'b0, ex(1, IH, 0, 0, B0), "blink_inc");
    for (int k = 1; k <= 12; k++)
      step(1'b0, 1'b0, 1'b0, ex(1, NO, 0, 0, ((k / 4) % 2 == 1) ? BH : B0),
           $sformatf("blink_hrs_%0d", k));
    step(1'b1, 1'b0, 1'b0, ex(2, NO, 0, 0, B0), "blink_min_enter");
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b0, ex(2, NO, 0, 0, (k == 4) ? BM : B0),
           $sformatf("blink_min_%0d", k));
    step(1'b1, 1'b0, 1'b0, ex(3, NO, 1, 0, B0), "blink_to_alm");
    step(1'b1, 1'b0, 1'b0, ex(4, NO, 0, 0, B0), "blink_to_almmin");
    step(1'b1, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "blink_to_run");
    for (int k = 0; k < 6; k++)
      step(1'b0, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), $sformatf("run_idle_%0d", k));

    // Inactivity timeout in ALM_MIN, restarted once by btnInc.
    step(1'b1, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "to_1");
    step(1'b1, 1'b0, 1'b0, ex(2, NO, 0, 0, B0), "to_2");
    step(1'b1, 1'b0, 1'b0, ex(3, NO, 1, 0, B0), "to_3");
    step(1'b1, 1'b0, 1'b0, ex(4, NO, 0, 0, B0), "to_4");
    step(1'b0, 1'b0, 1'b1, ex(4, NO,  0, 0, B0), "alm_tick1");
    step(1'b0, 1'b0, 1'b0, ex(4, NO,  0, 0, B0), "alm_idle1");
    step(1'b0, 1'b0, 1'b1, ex(4, NO,  0, 0, B0), "alm_tick2");
    step(1'b0, 1'b1, 1'b0, ex(4, IAM, 0, 0, B0), "alm_restart");
    step(1'b0, 1'b0, 1'b1, ex(4, NO,  0, 0, B0), "alm_tick1b");
    step(1'b0, 1'b0, 1'b0, ex(4, NO,  0, 0, B0), "alm_idle2");
    step(1'b0, 1'b0, 1'b1, ex(4, NO,  0, 0, B0), "alm_tick2b");
    step(1'b0, 1'b0, 1'b1, ex(4, NO,  0, 0, BM), "alm_tick3b");
`ifdef MODE_TIMEOUT_EN
    step(1'b0, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "alm_timeout");
`else
    step(1'b0, 1'b0, 1'b0, ex(4, NO, 0, 0, BM), "alm_no_timeout");
    step(1'b1, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "alm_back_run");
`endif

    // Timeout out of SET_MIN also clears seconds.
    step(1'b1, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "min_to_1");
    step(1'b1, 1'b0, 1'b0, ex(2, NO, 0, 0, B0), "min_to_2");
    step(1'b0, 1'b0, 1'b1, ex(2, NO, 0, 0, B0), "min_tick1");
    step(1'b0, 1'b0, 1'b1, ex(2, NO, 0, 0, B0), "min_tick2");
    step(1'b0, 1'b0, 1'b1, ex(2, NO, 0, 0, B0), "min_tick3");
`ifdef MODE_TIMEOUT_EN
    step(1'b0, 1'b0, 1'b0, ex(0, NO, 1, 0, B0), "min_timeout");
    step(1'b0, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "min_sclr_once");
`else
    step(1'b0, 1'b0, 1'b0, ex(2, NO, 0, 0, BM), "min_no_timeout");
    step(1'b1, 1'b0, 1'b0, ex(3, NO, 1, 0, B0), "min_back_3");
    step(1'b1, 1'b0, 1'b0, ex(4, NO, 0, 0, B0), "min_back_4");
    step(1'b1, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "min_back_run");
`endif

    // tickSec together with btnInc: the button clears the count.
    step(1'b1, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "coinc_enter");
    step(1'b0, 1'b0, 1'b1, ex(1, NO, 0, 0, B0), "coinc_tick1");
    step(1'b0, 1'b0, 1'b1, ex(1, NO, 0, 0, B0), "coinc_tick2");
    step(1'b0, 1'b1, 1'b1, ex(1, IH, 0, 0, B0), "coinc_tick_inc");
    step(1'b0, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "coinc_hold1");
    step(1'b0, 1'b0, 1'b0, ex(1, NO, 0, 0, B0), "coinc_hold2");
    step(1'b1, 1'b0, 1'b0, ex(2, NO, 0, 0, B0), "coinc_2");
    step(1'b1, 1'b0, 1'b0, ex(3, NO, 1, 0, B0), "coinc_3");
    step(1'b1, 1'b0, 1'b0, ex(4, NO, 0, 0, B0), "coinc_4");
    step(1'b1, 1'b0, 1'b0, ex(0, NO, 0, 0, B0), "coinc_run");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
